axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI read-channel arbiter. It shares the single external read port between the I-cache miss/bypass path (master 0) and the D-cache/LSU read path (master 1).
- Sits between both caches and the top-level AXI bridge.
- Grants one whole transaction (AR plus full R burst) at a time using round-robin priority, and registers the downstream AR channel.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
LEN_W, 8, AXI burst length field width
RESET_PRIO, 0, master that wins a simultaneous request first after reset (0 or 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_arvalid_i  in  1  I-side read address valid
m0_arready_o  out  1  I-side address accepted
m0_araddr_i  in  ADDR_W  I-side address
m0_arlen_i  in  LEN_W  I-side burst length minus 1
m0_rvalid_o  out  1  I-side read data valid
m0_rready_i  in  1  I-side data accept
m0_rdata_o  out  DATA_W  I-side read data
m0_rlast_o  out  1  I-side last beat
m1_*  (same six signals and widths as m0_*)  D-side equivalents
axi_arvalid_o  out  1  downstream address valid (registered)
axi_arready_i  in  1  downstream address ready
axi_araddr_o  out  ADDR_W  downstream address (registered)
axi_arlen_o  out  LEN_W  downstream burst length (registered)
axi_rvalid_i  in  1  downstream data valid
axi_rready_o  out  1  downstream data ready
axi_rdata_i  in  DATA_W  downstream data
axi_rlast_i  in  1  downstream last beat
len_err_o  out  1  sticky flag: rlast did not coincide with beat count == arlen

Behaviour:
- One clock `clk`; `rst` is synchronous, active-high.
- Reset values:
  - state = IDLE.
  - axi_arvalid_o = 0; axi_araddr_o = 0; axi_arlen_o = 0.
  - All m*_arready_o = 0; all m*_rvalid_o = 0.
  - len_err_o = 0; beat counter = 0; priority pointer = RESET_PRIO.
- States:
  - IDLE: no transaction in flight.
  - AR: downstream address outstanding.
  - R: data burst in flight.
- IDLE:
  - If exactly one m*_arvalid_i is high, that master wins.
  - If both are high, the master indicated by the priority pointer wins.
  - The winner's arready_o is driven combinationally high in that cycle; the upstream handshake completes there. The loser's arready_o stays 0.
  - On the clock edge: latch the winner's addr/len into the axi_ar* registers, set axi_arvalid_o = 1, record grant id, clear the beat counter, go to AR.
  - Latency: a request seen in cycle N produces axi_arvalid_o high in cycle N+1.
- AR:
  - axi_arvalid_o, axi_araddr_o and axi_arlen_o are held stable until axi_arready_i.
  - On the handshake edge: axi_arvalid_o = 0, go to R.
  - All m*_arready_o = 0 while in AR.
- R:
  - The granted master sees rvalid_o = axi_rvalid_i, with rdata/rlast passed through combinationally.
  - axi_rready_o = the granted master's rready_i.
  - The non-granted master sees rvalid_o = 0; its rdata_o is don't-care (drive 0).
  - Each beat handshake increments the beat counter (LEN_W+1 bits, no wrap for LEN_W = 8).
  - On a handshake with axi_rlast_i: go to IDLE; set the priority pointer to the other master.
  - If rlast arrives with count != arlen, set len_err_o; completion is still honoured.
  - If the count passes arlen without rlast, set len_err_o and keep routing until rlast.
- Back-to-back:
  - The earliest next grant is the cycle after the last-beat handshake (one-cycle IDLE bubble).
  - A master held off by a competitor wins next whenever it is still requesting (no starvation).
- Pointer: updates only on transaction completion, never on a grant alone.
- len_err_o: cleared only by rst.
- Reset mid-operation: returns to IDLE immediately and the outstanding downstream burst is abandoned. The slave must be reset by the same rst.
- Upstream arvalid deasserted before grant: it is not an error; the master simply is not considered.

Decomposition:
- Shared package (axi_arb_pkg):
  - State encodings IDLE = 2'd0, AR = 2'd1, R = 2'd2.
  - Grant ids GNT_M0 = 1'b0, GNT_M1 = 1'b1.
  - Default widths.
- Sub-module rr_arb2: combinational two-way round-robin picker. Inputs: two requests and the pointer. Outputs: one-hot grant plus grant id. Reusable for a future write-channel arbiter.

Test Plan:
- M0 only, addr 0x8000_0010, len 3, slave returns 4 beats 0x11..0x44 with rlast on beat 4 -> m0 receives 4 beats in order; m1_rvalid_o stays 0; IDLE one cycle after the last beat; len_err_o = 0.
- Both request in the same cycle after reset (RESET_PRIO = 0): M0 len 3, M1 addr 0x0f00_0004 len 0 -> M0 served first; M1 gets arready the cycle after M0's last beat; pointer ends at 0.
- M1 requests repeatedly while M0 holds arvalid high continuously -> grants strictly alternate M0, M1, M0 over 6 transactions.
- Slave drops axi_arready_i for 5 cycles -> axi_arvalid_o/araddr_o/arlen_o stable through all 5 cycles; no upstream arready in that window.
- Granted master deasserts rready for 3 cycles mid-burst -> axi_rready_o low for those 3 cycles; no beat lost or duplicated.
- Slave asserts rlast on beat 2 of a len 3 burst -> len_err_o = 1 and stays 1; arbiter returns to IDLE; rst clears the flag; rst asserted in state R -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter and its round-robin picker.
package axi_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the master named by i_ptr. Zero latency, no backpressure.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_ptr,
    output logic [1:0] o_gnt,
    output logic       o_gnt_id
);

    always_comb begin
        o_gnt_id = GNT_M0;
        o_gnt    = 2'b00;
        if (i_req0 && i_req1) begin
            o_gnt_id = i_ptr;
        end else if (i_req1) begin
            o_gnt_id = GNT_M1;
        end
        if (i_req0 || i_req1) begin
            o_gnt = (o_gnt_id == GNT_M1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: one whole transaction (AR + R burst) at a time, round-robin,
// registered AR (request in cycle N -> axi_arvalid_o in N+1); R backpressure passes straight through.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int RESET_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_arvalid_i,
    output logic              m0_arready_o,
    input  logic [ADDR_W-1:0] m0_araddr_i,
    input  logic [LEN_W-1:0]  m0_arlen_i,
    output logic              m0_rvalid_o,
    input  logic              m0_rready_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_rlast_o,
    input  logic              m1_arvalid_i,
    output logic              m1_arready_o,
    input  logic [ADDR_W-1:0] m1_araddr_i,
    input  logic [LEN_W-1:0]  m1_arlen_i,
    output logic              m1_rvalid_o,
    input  logic              m1_rready_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rlast_o,
    output logic              axi_arvalid_o,
    input  logic              axi_arready_i,
    output logic [ADDR_W-1:0] axi_araddr_o,
    output logic [LEN_W-1:0]  axi_arlen_o,
    input  logic              axi_rvalid_i,
    output logic              axi_rready_o,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic              axi_rlast_i,
    output logic              len_err_o
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_gnt_id;
    logic              r_ptr;
    logic              r_len_err;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [LEN_W-1:0]  r_arlen;
    logic [LEN_W:0]    r_cnt;

    logic [1:0]        w_gnt;
    logic              w_gnt_id;
    logic              w_take;
    logic              w_rready;
    logic              w_rhs;
    logic              w_len_bad;

    rr_arb2 u_pick (
        .i_req0   (m0_arvalid_i),
        .i_req1   (m1_arvalid_i),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign w_take    = (r_state == IDLE) && (|w_gnt);
    assign w_rready  = (r_gnt_id == GNT_M1) ? m1_rready_i : m0_rready_i;
    assign w_rhs     = (r_state == R) && axi_rvalid_i && w_rready;
    // r_cnt holds beats already accepted, so the current beat is last-legal when r_cnt == arlen
    assign w_len_bad = axi_rlast_i ? (r_cnt != {1'b0, r_arlen}) : (r_cnt >= {1'b0, r_arlen});

    assign axi_arvalid_o = r_arvalid;
    assign axi_araddr_o  = r_araddr;
    assign axi_arlen_o   = r_arlen;
    assign len_err_o     = r_len_err;

    always_comb begin
        w_state_nxt  = r_state;
        m0_arready_o = 1'b0;
        m1_arready_o = 1'b0;
        m0_rvalid_o  = 1'b0;
        m1_rvalid_o  = 1'b0;
        m0_rdata_o   = '0;
        m1_rdata_o   = '0;
        m0_rlast_o   = 1'b0;
        m1_rlast_o   = 1'b0;
        axi_rready_o = 1'b0;
        case (r_state)
            IDLE: begin
                m0_arready_o = !rst && w_gnt[0];
                m1_arready_o = !rst && w_gnt[1];
                if (w_take) w_state_nxt = AR;
            end
            AR: begin
                if (axi_arready_i) w_state_nxt = R;
            end
            R: begin
                axi_rready_o = w_rready;
                if (r_gnt_id == GNT_M1) begin
                    m1_rvalid_o = axi_rvalid_i;
                    m1_rdata_o  = axi_rdata_i;
                    m1_rlast_o  = axi_rlast_i;
                end else begin
                    m0_rvalid_o = axi_rvalid_i;
                    m0_rdata_o  = axi_rdata_i;
                    m0_rlast_o  = axi_rlast_i;
                end
                if (w_rhs && axi_rlast_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt_id  <= GNT_M0;
            r_ptr     <= 1'(RESET_PRIO);
            r_len_err <= 1'b0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_arvalid <= 1'b1;
                r_araddr  <= (w_gnt_id == GNT_M1) ? m1_araddr_i : m0_araddr_i;
                r_arlen   <= (w_gnt_id == GNT_M1) ? m1_arlen_i : m0_arlen_i;
                r_gnt_id  <= w_gnt_id;
                r_cnt     <= '0;
            end
            if ((r_state == AR) && axi_arready_i) begin
                r_arvalid <= 1'b0;
            end
            if (w_rhs) begin
                if (~&r_cnt) r_cnt <= r_cnt + (LEN_W+1)'(1);
                if (w_len_bad) r_len_err <= 1'b1;
                // fairness moves only when a transaction finishes, never on a bare grant
                if (axi_rlast_i) r_ptr <= ~r_gnt_id;
            end
        end
    end

endmodule
